// File: rtl/raw_acquire_prefetch.sv
// -----------------------------------------------------------------------------
// raw_acquire_prefetch
//
// Purpose:
//   Captures centre-phase oversampled antenna samples into off-chip DRAM through
//   the MCB command port. Once the whole address space has been written, it
//   streams the words back through a 2-slot prefetch buffer. That buffer feeds
//   the byte-wise read-back register of the acquisition Wishbone unit.
//
// Configuration macro:
//   RAW_ACQUIRE_TESTPATTERN_EN - when defined, each captured sample is replaced
//   by an AXNUM-bit counter. The counter starts at 0 and advances on every
//   sample pushed into the capture FIFO. signal_i is ignored in this mode.
//
// Parameters:
//   AXNUM  antenna count = sample width
//   ABITS  MCB word-address width; capture fills all 2^ABITS words
//   FBITS  log2 depth of the capture FIFO
//   DELAY  kept for interface compatibility; no delay is modelled in RTL
//
// Ports:
//   clock_i      system/bus clock
//   reset_i      synchronous active-high reset
//   locked_i     sampling PLL/aligner locked
//   strobe_i     new oversampled sample valid
//   middle_i     sample is the centre phase (only these are kept)
//   signal_i     antenna bits
//   capture_i    acquisition enable
//   data_sent_i  1-cycle pulse: current fetched word consumed
//   fetched_o    current prefetched read-back word
//   mcb_ce_o     MCB command strobe, one cycle per command
//   mcb_wr_o     1 = write, 0 = read (valid with mcb_ce_o)
//   mcb_rdy_i    MCB accepts a command this cycle
//   mcb_ack_i    read data valid on mcb_dat_i
//   mcb_adr_o    command word address
//   mcb_dat_i    read data, low AXNUM bits used
//   mcb_dat_o    write data, zero padded sample
//   oflow_o      sticky capture-FIFO overflow
//   state_o      FSM state (>2 means read-back active)
// -----------------------------------------------------------------------------
module raw_acquire_prefetch #(
    parameter int AXNUM = 24,
    parameter int ABITS = 21,
    parameter int FBITS = 4,
    parameter int DELAY = 3
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             locked_i,
    input  logic             strobe_i,
    input  logic             middle_i,
    input  logic [AXNUM-1:0] signal_i,
    input  logic             capture_i,
    input  logic             data_sent_i,
    output logic [AXNUM-1:0] fetched_o,
    output logic             mcb_ce_o,
    output logic             mcb_wr_o,
    input  logic             mcb_rdy_i,
    input  logic             mcb_ack_i,
    output logic [ABITS-1:0] mcb_adr_o,
    input  logic [31:0]      mcb_dat_i,
    output logic [31:0]      mcb_dat_o,
    output logic             oflow_o,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_READY   = 3'd3,
        ST_READ    = 3'd4
    } state_t;

    localparam int FDEPTH = 1 << FBITS;
    localparam logic [FBITS:0] FIFO_FULL_CNT = {1'b1, {FBITS{1'b0}}};

    state_t           state_q;
    logic             mcb_ce_q;
    logic             mcb_wr_q;
    logic [ABITS-1:0] mcb_adr_q;
    logic [31:0]      mcb_dat_q;
    logic             oflow_q;
    logic [ABITS-1:0] wadr_q;
    logic [ABITS-1:0] radr_q;

    // Capture FIFO: pointers carry one extra bit so full and empty differ.
    logic [AXNUM-1:0] fifo_mem [FDEPTH];
    logic [FBITS:0]   fifo_wr_q;
    logic [FBITS:0]   fifo_rd_q;
    logic [FBITS:0]   fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    logic             accept;
    logic             push;
    logic             pop;
    logic [AXNUM-1:0] sample_in;

    // Prefetch slots: cur is what the read-back register sees, nxt is the spare.
    logic [AXNUM-1:0] cur_q, cur_d;
    logic [AXNUM-1:0] nxt_q, nxt_d;
    logic             cur_v_q, cur_v_d;
    logic             nxt_v_q, nxt_v_d;
    logic             fill;
    logic             prefetch_req;
    logic [AXNUM-1:0] ack_word;

    assign fifo_count = fifo_wr_q - fifo_rd_q;
    assign fifo_full  = (fifo_count == FIFO_FULL_CNT);
    assign fifo_empty = (fifo_wr_q == fifo_rd_q);

    assign accept = capture_i && locked_i && strobe_i && middle_i && (state_q == ST_CAPTURE);
    assign push   = accept && !fifo_full;
    assign pop    = (state_q == ST_CAPTURE) && !fifo_empty && mcb_rdy_i;

    assign ack_word     = mcb_dat_i[AXNUM-1:0];
    assign fill         = (state_q == ST_READ) && mcb_ack_i;
    // Only one read can be in flight, so a request needs just one free slot.
    assign prefetch_req = !(cur_v_q && nxt_v_q);

`ifdef RAW_ACQUIRE_TESTPATTERN_EN
    logic [AXNUM-1:0] pattern_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pattern_q <= '0;
        end else if (push) begin
            pattern_q <= pattern_q + 1'b1;
        end
    end

    assign sample_in = pattern_q;

    logic unused_ok;
    assign unused_ok = ^{mcb_dat_i, signal_i, 32'(DELAY)};
`else
    assign sample_in = signal_i;

    logic unused_ok;
    assign unused_ok = ^{mcb_dat_i, 32'(DELAY)};
`endif

    // FIFO storage carries no reset so that it maps onto RAM.
    always_ff @(posedge clock_i) begin
        if (push) begin
            fifo_mem[fifo_wr_q[FBITS-1:0]] <= sample_in;
        end
    end

    // A consume shifts the slots first; the arriving word then fills the
    // first empty slot. This keeps order when both events share a cycle.
    always_comb begin
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        cur_v_d = cur_v_q;
        nxt_v_d = nxt_v_q;
        if (data_sent_i && cur_v_q) begin
            cur_d   = nxt_q;
            cur_v_d = nxt_v_q;
            nxt_v_d = 1'b0;
        end
        if (fill) begin
            if (!cur_v_d) begin
                cur_d   = ack_word;
                cur_v_d = 1'b1;
            end else begin
                nxt_d   = ack_word;
                nxt_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cur_q   <= '0;
            nxt_q   <= '0;
            cur_v_q <= 1'b0;
            nxt_v_q <= 1'b0;
        end else begin
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            cur_v_q <= cur_v_d;
            nxt_v_q <= nxt_v_d;
        end
    end

    // Control FSM together with the MCB command registers and the FIFO pointers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            mcb_ce_q  <= 1'b0;
            mcb_wr_q  <= 1'b0;
            mcb_adr_q <= '0;
            mcb_dat_q <= '0;
            oflow_q   <= 1'b0;
            wadr_q    <= '0;
            radr_q    <= '0;
            fifo_wr_q <= '0;
            fifo_rd_q <= '0;
        end else begin
            mcb_ce_q <= 1'b0;
            if (push) begin
                fifo_wr_q <= fifo_wr_q + 1'b1;
            end
            if (accept && fifo_full) begin
                oflow_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (capture_i && locked_i) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (pop) begin
                        mcb_ce_q  <= 1'b1;
                        mcb_wr_q  <= 1'b1;
                        mcb_adr_q <= wadr_q;
                        mcb_dat_q <= 32'(fifo_mem[fifo_rd_q[FBITS-1:0]]);
                        fifo_rd_q <= fifo_rd_q + 1'b1;
                        wadr_q    <= wadr_q + 1'b1;
                        // The last address has been written, so the memory is full.
                        if (wadr_q == '1) begin
                            state_q <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_READY;
                end
                ST_READY: begin
                    if (prefetch_req && mcb_rdy_i) begin
                        mcb_ce_q  <= 1'b1;
                        mcb_wr_q  <= 1'b0;
                        mcb_adr_q <= radr_q;
                        radr_q    <= radr_q + 1'b1;
                        state_q   <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (mcb_ack_i) begin
                        state_q <= ST_READY;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign fetched_o = cur_q;
    assign mcb_ce_o  = mcb_ce_q;
    assign mcb_wr_o  = mcb_wr_q;
    assign mcb_adr_o = mcb_adr_q;
    assign mcb_dat_o = mcb_dat_q;
    assign oflow_o   = oflow_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_raw_acquire_prefetch.sv
// -----------------------------------------------------------------------------
// tb_raw_acquire_prefetch
//
// The bench runs raw_acquire_prefetch with a 16-word DRAM (ABITS=4).
// A vector table covers the sample-accept gating. Hand-written sequences
// cover the overflow and full-capture case and the read-back prefetch.
// -----------------------------------------------------------------------------
module tb_raw_acquire_prefetch;

    localparam int AXNUM = 24;
    localparam int ABITS = 4;

    logic             clk = 1'b0;
    logic             reset_i;
    logic             locked_i;
    logic             strobe_i;
    logic             middle_i;
    logic [AXNUM-1:0] signal_i;
    logic             capture_i;
    logic             data_sent_i;
    logic [AXNUM-1:0] fetched_o;
    logic             mcb_ce_o;
    logic             mcb_wr_o;
    logic             mcb_rdy_i;
    logic             mcb_ack_i;
    logic [ABITS-1:0] mcb_adr_o;
    logic [31:0]      mcb_dat_i;
    logic [31:0]      mcb_dat_o;
    logic             oflow_o;
    logic [2:0]       state_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    raw_acquire_prefetch #(
        .AXNUM(AXNUM),
        .ABITS(ABITS),
        .FBITS(4),
        .DELAY(3)
    ) dut (
        .clock_i    (clk),
        .reset_i    (reset_i),
        .locked_i   (locked_i),
        .strobe_i   (strobe_i),
        .middle_i   (middle_i),
        .signal_i   (signal_i),
        .capture_i  (capture_i),
        .data_sent_i(data_sent_i),
        .fetched_o  (fetched_o),
        .mcb_ce_o   (mcb_ce_o),
        .mcb_wr_o   (mcb_wr_o),
        .mcb_rdy_i  (mcb_rdy_i),
        .mcb_ack_i  (mcb_ack_i),
        .mcb_adr_o  (mcb_adr_o),
        .mcb_dat_i  (mcb_dat_i),
        .mcb_dat_o  (mcb_dat_o),
        .oflow_o    (oflow_o),
        .state_o    (state_o)
    );

    typedef struct {
        logic             locked;
        logic             strobe;
        logic             middle;
        logic             capture;
        logic [AXNUM-1:0] sig;
        logic             exp_push;
        logic [ABITS-1:0] exp_adr;
    } vec_t;

    vec_t vecs [6];

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // The expected written sample depends on whether the counter pattern replaces the input.
    function automatic logic [AXNUM-1:0] exp_sample(input int idx, input logic [AXNUM-1:0] sig);
`ifdef RAW_ACQUIRE_TESTPATTERN_EN
        logic [31:0] idx_w;
        idx_w = idx;
        return idx_w[AXNUM-1:0];
`else
        return sig;
`endif
    endfunction

    task automatic do_reset();
        reset_i     = 1'b1;
        locked_i    = 1'b0;
        strobe_i    = 1'b0;
        middle_i    = 1'b0;
        signal_i    = '0;
        capture_i   = 1'b0;
        data_sent_i = 1'b0;
        mcb_rdy_i   = 1'b0;
        mcb_ack_i   = 1'b0;
        mcb_dat_i   = '0;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    // Wait, within a bounded number of cycles, for a command strobe.
    task automatic wait_ce(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mcb_ce_o) begin
                got = 1'b1;
                break;
            end
        end
        check(name, {31'd0, got}, 32'd1);
    endtask

    // Return one read word on the bus for a single cycle.
    task automatic ack_word(input logic [31:0] dat, input logic sent);
        mcb_ack_i   = 1'b1;
        mcb_dat_i   = dat;
        data_sent_i = sent;
        tick();
        mcb_ack_i   = 1'b0;
        data_sent_i = 1'b0;
        $display("read ack dat=0x%08h sent=%0d -> fetched=0x%06h", dat, sent, fetched_o);
    endtask

    initial begin
        int pushes;
        int ce_seen;
        int k;

        // locked, strobe, middle, capture, sig, exp_push, exp_adr
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 24'h000001, 1'b1, 4'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 24'h000002, 1'b0, 4'd0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 24'h000003, 1'b0, 4'd0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 24'h000004, 1'b0, 4'd0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 24'h000005, 1'b0, 4'd0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 24'hABCDEF, 1'b1, 4'd1};

        // ---------------- reset state ----------------
        do_reset();
        check("reset_state", {29'd0, state_o}, 32'd0);
        check("reset_ce", {31'd0, mcb_ce_o}, 32'd0);
        check("reset_wr", {31'd0, mcb_wr_o}, 32'd0);
        check("reset_adr", {28'd0, mcb_adr_o}, 32'd0);
        check("reset_dat", mcb_dat_o, 32'd0);
        check("reset_fetched", {8'd0, fetched_o}, 32'd0);
        check("reset_oflow", {31'd0, oflow_o}, 32'd0);

        // ---------------- accept gating (table) ----------------
        capture_i = 1'b1;
        locked_i  = 1'b1;
        mcb_rdy_i = 1'b1;
        tick();
        check("enter_capture", {29'd0, state_o}, 32'd1);
        pushes = 0;
        for (int v = 0; v < 6; v++) begin
            locked_i  = vecs[v].locked;
            strobe_i  = vecs[v].strobe;
            middle_i  = vecs[v].middle;
            capture_i = vecs[v].capture;
            signal_i  = vecs[v].sig;
            tick();
            strobe_i  = 1'b0;
            middle_i  = 1'b0;
            locked_i  = 1'b1;
            capture_i = 1'b1;
            tick();
            $display("vec %0d: l=%0d s=%0d m=%0d c=%0d -> ce=%0d adr=%0d dat=0x%08h",
                     v, vecs[v].locked, vecs[v].strobe, vecs[v].middle, vecs[v].capture,
                     mcb_ce_o, mcb_adr_o, mcb_dat_o);
            check($sformatf("gate_ce_%0d", v), {31'd0, mcb_ce_o}, {31'd0, vecs[v].exp_push});
            if (vecs[v].exp_push) begin
                check($sformatf("gate_wr_%0d", v), {31'd0, mcb_wr_o}, 32'd1);
                check($sformatf("gate_adr_%0d", v), {28'd0, mcb_adr_o}, {28'd0, vecs[v].exp_adr});
                check($sformatf("gate_dat_%0d", v), mcb_dat_o,
                      {8'd0, exp_sample(pushes, vecs[v].sig)});
                pushes++;
            end
        end

        // ---------------- overflow, then full 16-word capture ----------------
        do_reset();
        capture_i = 1'b1;
        locked_i  = 1'b1;
        mcb_rdy_i = 1'b0;
        tick();
        ce_seen = 0;
        for (int i = 0; i < 17; i++) begin
            strobe_i = 1'b1;
            middle_i = 1'b1;
            signal_i = 24'h000100 + 24'(i);
            tick();
            if (mcb_ce_o) ce_seen++;
        end
        strobe_i = 1'b0;
        middle_i = 1'b0;
        tick();
        if (mcb_ce_o) ce_seen++;
        check("oflow_set", {31'd0, oflow_o}, 32'd1);
        check("no_ce_without_rdy", ce_seen, 32'd0);

        mcb_rdy_i = 1'b1;
        k = 0;
        for (int c = 0; c < 60 && k < 16; c++) begin
            tick();
            if (mcb_ce_o) begin
                $display("write adr=%0d dat=0x%08h wr=%0d state=%0d", mcb_adr_o, mcb_dat_o, mcb_wr_o, state_o);
                check($sformatf("cap_wr_%0d", k), {31'd0, mcb_wr_o}, 32'd1);
                check($sformatf("cap_adr_%0d", k), {28'd0, mcb_adr_o}, k);
                check($sformatf("cap_dat_%0d", k), mcb_dat_o,
                      {8'd0, exp_sample(k, 24'h000100 + 24'(k))});
                k++;
                if (k == 16) begin
                    mcb_rdy_i = 1'b0;
                    check("state_flush", {29'd0, state_o}, 32'd2);
                end
            end
        end
        check("capture_write_count", k, 32'd16);
        tick();
        check("state_ready", {29'd0, state_o}, 32'd3);
        check("oflow_sticky", {31'd0, oflow_o}, 32'd1);

        // ---------------- read-back prefetch ----------------
        // With an empty buffer, data_sent is ignored. An ack outside READ is ignored too.
        data_sent_i = 1'b1;
        tick();
        data_sent_i = 1'b0;
        ack_word(32'h00123456, 1'b0);
        check("stray_ack_fetched", {8'd0, fetched_o}, 32'd0);
        check("stray_ack_state", {29'd0, state_o}, 32'd3);
        check("no_read_without_rdy", {31'd0, mcb_ce_o}, 32'd0);

        mcb_rdy_i = 1'b1;
        wait_ce("read0_ce");
        check("read0_wr", {31'd0, mcb_wr_o}, 32'd0);
        check("read0_adr", {28'd0, mcb_adr_o}, 32'd0);
        check("read0_state", {29'd0, state_o}, 32'd4);
        ack_word(32'h00ABCDEF, 1'b0);
        check("read0_fetched", {8'd0, fetched_o}, 32'h00ABCDEF);
        check("read0_back_ready", {29'd0, state_o}, 32'd3);

        wait_ce("read1_ce");
        check("read1_adr", {28'd0, mcb_adr_o}, 32'd1);
        ack_word(32'hFF111111, 1'b0);
        check("read1_fetched_held", {8'd0, fetched_o}, 32'h00ABCDEF);
        ce_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mcb_ce_o) ce_seen++;
        end
        check("no_req_when_full", ce_seen, 32'd0);

        data_sent_i = 1'b1;
        tick();
        data_sent_i = 1'b0;
        check("sent_shift", {8'd0, fetched_o}, 32'h00111111);

        wait_ce("read2_ce");
        check("read2_adr", {28'd0, mcb_adr_o}, 32'd2);
        ack_word(32'h00222222, 1'b1);
        check("sent_and_ack", {8'd0, fetched_o}, 32'h00222222);

        wait_ce("read3_ce");
        check("read3_adr", {28'd0, mcb_adr_o}, 32'd3);
        ack_word(32'h00333333, 1'b0);
        check("read3_fetched_held", {8'd0, fetched_o}, 32'h00222222);
        data_sent_i = 1'b1;
        tick();
        data_sent_i = 1'b0;
        check("read3_order", {8'd0, fetched_o}, 32'h00333333);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
